wbarb: RTL and testbench
========================

# wbarb

Writeback arbiter at the consumer end of the functional-unit result/claim interface. Every execution unit (alu, mul, div, lsu, …) presents finished results as `exe_bundle_t` entries and holds each one until it is claimed. `wbarb` selects up to `wbw` results per cycle in round-robin order and asserts `claim` for each one it takes. It also claims and discards results squashed by a redirect, and registers the granted results onto the writeback bus for the register file, wakeup and ROB completion.

## Interface
- `nfu`, 4: number of functional-unit ports.
- `ewd`, 2: result slots per functional unit (matches the unit's `ewd`).
- `wbw`, 2: writeback width, the maximum number of results forwarded per cycle.
- `opsz`, 64: operation ID space; must be a power of two.

- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `redir`  in  `red_bundle_t`: redirect bundle; `opid[15]` is the valid bit, `topid` is the oldest in-flight ID.
- `resp`  in  `[nfu-1:0][ewd-1:0] exe_bundle_t`: FU results; a slot is valid when `opid[15]` is set.
- `stall`  in  1: writeback consumer cannot accept new results this cycle.
- `claim`  out  `[nfu-1:0][ewd-1:0]`: combinational; the slot is taken this cycle.
- `wb`  out  `[wbw-1:0] exe_bundle_t`: registered writeback entries; valid when `opid[15]` is set.

## Operation
- Flattened candidate index: k = f*ewd + e, for k in 0..nfu*ewd-1.
- Squash test `younger(opid, redir)` is true when all of the following hold, with all arithmetic done in `$clog2(opsz)` bits (wraps mod `opsz`):
  - `redir.opid[15]` is set;
  - `opid[15]` is set;
  - (opid − topid) ≥ (redir.opid − topid) + 1.
- Squashed candidate (valid and younger):
  - `claim` is asserted for it unconditionally, even while `stall` is high;
  - it is never forwarded;
  - it does not consume writeback width.
- Live candidate (valid and not younger):
  - eligible only when `stall` is low;
  - grant the first `wbw` live candidates scanning k = `rrptr`, `rrptr`+1, … modulo nfu*ewd;
  - grants are packed into `wb[0..g-1]` in scan order;
  - unused `wb` lanes are written with all zeros.
- Round-robin pointer `rrptr` (`$clog2(nfu*ewd)` bits, wrapping modulo nfu*ewd):
  - g > 0 grants this cycle: next `rrptr` = (index of last grant + 1) mod nfu*ewd;
  - no grant: `rrptr` holds.
- `stall` high:
  - `wb` holds its contents;
  - no live claims are made;
  - each held lane whose `opid` is `younger` than the current `redir` has its `opid` cleared to 0 at that clock edge.
- Redirect in the same cycle as a grant: the squash test uses the current `redir`, so a just-squashed result is dropped, never registered.

## Timing
- Claim to writeback: the result claimed in cycle t appears on `wb` in cycle t+1, and is valid for exactly one cycle when `stall` is low.
- The FU must remove a claimed entry by the next edge; `wbarb` never claims the same slot twice for one result.
- Reset, asynchronous: `wb` goes to all zeros and `rrptr` goes to 0 immediately, mid-operation included.
- `claim` depends only on `resp`, `redir`, `stall` and `rrptr`, so `claim` is 0 whenever no slot is valid.
- All slots live with `wbw` < nfu*ewd: each slot is granted at least once every ceil(nfu*ewd / `wbw`) unstalled cycles.

## Configuration
- `WBARB_STAT_EN` defined:
  - adds output `wb_cnt` (32 bits): count of forwarded results;
  - adds output `sq_cnt` (32 bits): count of squashed claims;
  - both reset to 0 and wrap at 2^32.
- `WBARB_STAT_EN` undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- The squash-order function `younger(opid, redir, opsz)` belongs in the `types` package, shared by every FU and this block.
- `wbarb_pick` sub-module: combinational rotate-and-pick-first-`wbw` selector.
  - Inputs: live mask, `rrptr`.
  - Outputs: grant mask, per-lane source index, last-grant index.

## Test plan
- Single result: nfu=4, ewd=2, `wbw`=2, only slot k=5 valid with opid=0x8003, no redirect.
  - `claim[2][1]`=1 in cycle t.
  - `wb[0].opid`=0x8003 in t+1; `wb[1]`=0.
  - `rrptr`=6.
- Round-robin: all 8 slots valid, starting from `rrptr`=0.
  - Grants are {0,1}, {2,3}, {4,5}, {6,7}, {0,1} on successive cycles.
- Squash:
  - Setup: `redir.opid`=0x8010, `topid`=0x0C, slots hold IDs 0x800E, 0x8011, 0x8012.
  - 0x8011 and 0x8012 are claimed and dropped.
  - Only 0x800E reaches `wb`.
  - With `WBARB_STAT_EN`: `sq_cnt`=2.
- Wrap-around:
  - IDs: `topid`=0x3E, `redir.opid`=0x8001, candidate 0x803F.
  - 0x803F is older, so it is forwarded.
  - Candidate 0x8002 is dropped.
- Stall:
  - `stall`=1 with `wb[0].opid`=0x8020 held.
  - A redirect arrives with `redir.opid`=0x801F.
  - `wb[0].opid` becomes 0; no live claims are made while stalled.
- Reset mid-stream: assert `rst` between edges while grants are flowing.
  - `wb` and `rrptr` are 0 immediately.
  - First grant after release starts at k=0.

Source files
------------

// File: rtl/wbarb_pkg.sv
// wbarb_pkg: shared writeback types, sizing and the squash-order helper.
//   exe_bundle_t : functional-unit result (opid[15] = valid)
//   red_bundle_t : redirect (opid[15] = valid, topid = oldest in-flight ID)
//   younger()    : true when a valid opid lies after a valid redirect point
package wbarb_pkg;

    localparam int unsigned NFU   = 4;
    localparam int unsigned EWD   = 2;
    localparam int unsigned WBW   = 2;
    localparam int unsigned OPSZ  = 64;
    localparam int unsigned NSLOT = NFU * EWD;
    localparam int unsigned PTRW  = $clog2(NSLOT);
    localparam int unsigned OPIDW = 16;
    localparam int unsigned RDW   = 6;
    localparam int unsigned DATAW = 64;
    localparam int unsigned CNTW  = 32;

    typedef struct packed {
        logic [OPIDW-1:0] opid;
        logic [RDW-1:0]   rd;
        logic [DATAW-1:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [OPIDW-1:0] opid;
        logic [OPIDW-1:0] topid;
        logic [DATAW-1:0] tgt;
    } red_bundle_t;

    // Age is measured as distance from topid inside the opsz-wide ID ring.
    function automatic logic younger(input logic [OPIDW-1:0] opid,
                                     input red_bundle_t       redir,
                                     input int unsigned       opsz);
        logic [OPIDW-1:0] mask;
        logic [OPIDW-1:0] d_op;
        logic [OPIDW-1:0] d_rd;
        mask = OPIDW'(opsz - 1);
        d_op = (opid - redir.topid) & mask;
        d_rd = (redir.opid - redir.topid + OPIDW'(1)) & mask;
        return redir.opid[OPIDW-1] && opid[OPIDW-1] && (d_op >= d_rd);
    endfunction

endpackage

// File: rtl/wbarb_pick.sv
// wbarb_pick: rotate-and-pick-first-W selector.
//   live_i     : candidates eligible for a grant
//   rrptr_i    : scan start index
//   gnt_o      : granted candidates
//   lane_vld_o : lane j carries a grant
//   lane_idx_o : source index per lane, packed in scan order
//   last_o     : index of the final grant in scan order
//   any_o      : at least one grant
module wbarb_pick #(
    parameter  int unsigned N  = 8,
    parameter  int unsigned W  = 2,
    localparam int unsigned PW = $clog2(N),
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [N-1:0]         live_i,
    input  logic [PW-1:0]        rrptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [W-1:0]         lane_vld_o,
    output logic [W-1:0][PW-1:0] lane_idx_o,
    output logic [PW-1:0]        last_o,
    output logic                 any_o
);

    // Scan position i maps to candidate (rrptr + i) mod N.
    always_comb begin
        logic [2*N-1:0] rot;
        logic [PW:0]    pos;
        logic [CW-1:0]  cnt;
        gnt_o      = '0;
        lane_vld_o = '0;
        lane_idx_o = '0;
        last_o     = '0;
        any_o      = 1'b0;
        cnt        = '0;
        pos        = '0;
        rot        = {live_i, live_i} >> rrptr_i;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, rrptr_i} + (PW+1)'(i);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (rot[i] && (cnt < CW'(W))) begin
                gnt_o = gnt_o | (N'(1) << pos);
                for (int unsigned j = 0; j < W; j++) begin
                    if (cnt == CW'(j)) begin
                        lane_vld_o[j] = 1'b1;
                        lane_idx_o[j] = pos[PW-1:0];
                    end
                end
                last_o = pos[PW-1:0];
                any_o  = 1'b1;
                cnt    = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wbarb.sv
// wbarb: writeback arbiter. Claims up to WBW live FU results per cycle in
// round-robin order, claims and drops redirect-squashed results, and
// registers grants onto the writeback bus.
//   clk, rst : clock, asynchronous active-high reset
//   redir    : redirect bundle
//   resp     : FU result slots [NFU][EWD]
//   stall    : writeback consumer not accepting
//   claim    : combinational per-slot take
//   wb       : registered writeback lanes
// Optional statistics (macro WBARB_STAT_EN): wb_cnt forwarded results,
// sq_cnt squashed claims.
module wbarb
    import wbarb_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  red_bundle_t                     redir,
    input  exe_bundle_t [NFU-1:0][EWD-1:0]  resp,
    input  logic                            stall,
    output logic        [NFU-1:0][EWD-1:0]  claim,
    output exe_bundle_t [WBW-1:0]           wb
`ifdef WBARB_STAT_EN
    ,
    output logic [CNTW-1:0]                 wb_cnt,
    output logic [CNTW-1:0]                 sq_cnt
`endif
);

    exe_bundle_t [NSLOT-1:0]         cand;
    logic        [NSLOT-1:0]         sq;
    logic        [NSLOT-1:0]         live;
    logic        [NSLOT-1:0]         gnt;
    logic        [WBW-1:0]           lane_vld;
    logic        [WBW-1:0][PTRW-1:0] lane_idx;
    logic        [PTRW-1:0]          last_idx;
    logic                            any_gnt;

    exe_bundle_t [WBW-1:0]           wb_q, wb_d;
    logic        [PTRW-1:0]          rrptr_q, rrptr_d;

    // Flatten slots (k = f*EWD + e) and split into squashed / live.
    always_comb begin
        cand = '0;
        sq   = '0;
        live = '0;
        for (int unsigned f = 0; f < NFU; f++) begin
            for (int unsigned e = 0; e < EWD; e++) begin
                cand[f*EWD+e] = resp[f][e];
            end
        end
        for (int unsigned k = 0; k < NSLOT; k++) begin
            sq[k]   = younger(cand[k].opid, redir, OPSZ);
            live[k] = cand[k].opid[OPIDW-1] && !sq[k] && !stall;
        end
    end

    wbarb_pick #(
        .N (NSLOT),
        .W (WBW)
    ) u_pick (
        .live_i     (live),
        .rrptr_i    (rrptr_q),
        .gnt_o      (gnt),
        .lane_vld_o (lane_vld),
        .lane_idx_o (lane_idx),
        .last_o     (last_idx),
        .any_o      (any_gnt)
    );

    // Squashed slots are claimed even under stall; live ones only when granted.
    always_comb begin
        claim = '0;
        for (int unsigned f = 0; f < NFU; f++) begin
            for (int unsigned e = 0; e < EWD; e++) begin
                claim[f][e] = sq[f*EWD+e] | gnt[f*EWD+e];
            end
        end
    end

    // Stall holds the bus but still kills held lanes behind a redirect.
    always_comb begin
        wb_d    = wb_q;
        rrptr_d = rrptr_q;
        if (stall) begin
            for (int unsigned j = 0; j < WBW; j++) begin
                if (younger(wb_q[j].opid, redir, OPSZ)) begin
                    wb_d[j].opid = '0;
                end
            end
        end else begin
            wb_d = '0;
            for (int unsigned j = 0; j < WBW; j++) begin
                if (lane_vld[j]) begin
                    wb_d[j] = cand[lane_idx[j]];
                end
            end
            if (any_gnt) begin
                rrptr_d = (last_idx == PTRW'(NSLOT - 1)) ? '0 : last_idx + PTRW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q    <= '0;
            rrptr_q <= '0;
        end else begin
            wb_q    <= wb_d;
            rrptr_q <= rrptr_d;
        end
    end

    assign wb = wb_q;

`ifdef WBARB_STAT_EN
    logic [CNTW-1:0] wb_cnt_q, wb_cnt_d;
    logic [CNTW-1:0] sq_cnt_q, sq_cnt_d;

    // Per-cycle increments; counters wrap naturally.
    always_comb begin
        wb_cnt_d = wb_cnt_q;
        sq_cnt_d = sq_cnt_q;
        for (int unsigned j = 0; j < WBW; j++) begin
            wb_cnt_d = wb_cnt_d + CNTW'(lane_vld[j]);
        end
        for (int unsigned k = 0; k < NSLOT; k++) begin
            sq_cnt_d = sq_cnt_d + CNTW'(sq[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cnt_q <= '0;
            sq_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    assign wb_cnt = wb_cnt_q;
    assign sq_cnt = sq_cnt_q;
`endif

endmodule

// File: tb/tb_wbarb.sv
// tb_wbarb: scoreboard bench for wbarb. Expected writeback lanes are queued
// when a cycle's stimulus is driven and compared after the following edge.
module tb_wbarb;
    import wbarb_pkg::*;

    typedef exe_bundle_t [WBW-1:0] wbvec_t;

    logic                           clk = 1'b0;
    logic                           rst;
    red_bundle_t                    redir;
    exe_bundle_t [NFU-1:0][EWD-1:0] resp;
    exe_bundle_t [NSLOT-1:0]        resp_flat;
    logic                           stall;
    logic        [NFU-1:0][EWD-1:0] claim;
    exe_bundle_t [WBW-1:0]          wb;
`ifdef WBARB_STAT_EN
    logic [CNTW-1:0] wb_cnt, sq_cnt;
    logic [CNTW-1:0] s_wb, s_sq;
`endif

    wbvec_t exp_q[$];
    int     n_chk = 0;
    int     n_err = 0;

    assign resp = resp_flat;

    always #5 clk = ~clk;

    wbarb dut (
        .clk   (clk),
        .rst   (rst),
        .redir (redir),
        .resp  (resp),
        .stall (stall),
        .claim (claim),
        .wb    (wb)
`ifdef WBARB_STAT_EN
        ,
        .wb_cnt (wb_cnt),
        .sq_cnt (sq_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exe_bundle_t mk(input logic [15:0] id);
        exe_bundle_t r;
        r.opid = id;
        r.rd   = id[5:0];
        r.data = {32'hDA7A_0000, 16'h0000, id};
        return r;
    endfunction

    task automatic set_slot(input int k, input logic [15:0] id);
        if (id == 16'h0) resp_flat[PTRW'(k)] = '0;
        else             resp_flat[PTRW'(k)] = mk(id);
    endtask

    // One cycle: check claim mid-cycle, queue expected lanes, compare after edge.
    task automatic step(input logic [NSLOT-1:0] exp_claim, input exe_bundle_t e0,
                        input exe_bundle_t e1, input string tag);
        wbvec_t ev;
        wbvec_t want;
        @(negedge clk);
        chk({tag, ":claim"}, 128'(claim), 128'(exp_claim));
        ev[0] = e0;
        ev[1] = e1;
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk({tag, ":wb0"}, 128'(wb[0]), 128'(want[0]));
        chk({tag, ":wb1"}, 128'(wb[1]), 128'(want[1]));
    endtask

    initial begin
        exe_bundle_t z;
        exe_bundle_t held;
        logic [15:0] ids [NSLOT];
        logic [15:0] nid;
        int          base;

        z         = '0;
        rst       = 1'b1;
        stall     = 1'b0;
        redir     = '0;
        resp_flat = '0;

        // Reset state
        #12;
        chk("rst_wb0", 128'(wb[0]), 128'(0));
        chk("rst_wb1", 128'(wb[1]), 128'(0));
        chk("rst_rrptr", 128'(dut.rrptr_q), 128'(0));
        chk("rst_claim", 128'(claim), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single result at k=5
        set_slot(5, 16'h8003);
        step(8'h20, mk(16'h8003), z, "single");
        chk("single_rrptr", 128'(dut.rrptr_q), 128'(6));
        set_slot(5, 16'h0);
        step(8'h00, z, z, "single_gap");

        // Squash: 0x8011/0x8012 claimed and dropped, 0x800E forwarded
        redir.opid  = 16'h8010;
        redir.topid = 16'h000C;
        set_slot(0, 16'h800E);
        set_slot(1, 16'h8011);
        set_slot(2, 16'h8012);
`ifdef WBARB_STAT_EN
        s_sq = sq_cnt;
        s_wb = wb_cnt;
`endif
        step(8'h07, mk(16'h800E), z, "squash");
`ifdef WBARB_STAT_EN
        chk("squash_sqcnt", 128'(sq_cnt - s_sq), 128'(2));
        chk("squash_wbcnt", 128'(wb_cnt - s_wb), 128'(1));
`endif
        chk("squash_rrptr", 128'(dut.rrptr_q), 128'(1));
        set_slot(0, 16'h0);
        set_slot(1, 16'h0);
        set_slot(2, 16'h0);

        // ID wrap-around
        redir.opid  = 16'h8001;
        redir.topid = 16'h003E;
        set_slot(3, 16'h803F);
        set_slot(4, 16'h8002);
        step(8'h18, mk(16'h803F), z, "wrap");
        set_slot(3, 16'h0);
        set_slot(4, 16'h0);
        redir = '0;

        // Pointer wrap with more live candidates than lanes
        set_slot(6, 16'h8046);
        step(8'h40, mk(16'h8046), z, "pick_a");
        chk("pick_a_rrptr", 128'(dut.rrptr_q), 128'(7));
        set_slot(6, 16'h8056);
        set_slot(7, 16'h8047);
        set_slot(0, 16'h8040);
        step(8'h81, mk(16'h8047), mk(16'h8040), "pick_b");
        chk("pick_b_rrptr", 128'(dut.rrptr_q), 128'(1));
        set_slot(7, 16'h0);
        set_slot(0, 16'h0);
        step(8'h40, mk(16'h8056), z, "pick_c");
        chk("pick_c_rrptr", 128'(dut.rrptr_q), 128'(7));
        set_slot(6, 16'h0);

        // Stall: hold, no live claims, then redirect kills the held lane
        set_slot(0, 16'h8020);
        step(8'h01, mk(16'h8020), z, "stall_fill");
        set_slot(0, 16'h0);
        stall = 1'b1;
        set_slot(1, 16'h8021);
        step(8'h00, mk(16'h8020), z, "stall_hold");
        chk("stall_rrptr", 128'(dut.rrptr_q), 128'(1));
        redir.opid  = 16'h801F;
        redir.topid = 16'h0000;
        held        = mk(16'h8020);
        held.opid   = '0;
        step(8'h02, held, z, "stall_redir");
        set_slot(1, 16'h0);
        redir = '0;
        stall = 1'b0;
        set_slot(2, 16'h8022);
        step(8'h04, mk(16'h8022), z, "stall_release");
        set_slot(2, 16'h0);

        // Reset mid-stream with all slots valid
        nid = 16'h8060;
        for (int k = 0; k < int'(NSLOT); k++) begin
            ids[k] = nid;
            set_slot(k, nid);
            nid    = nid + 16'h1;
        end
        step(8'h18, mk(ids[3]), mk(ids[4]), "mid");
        ids[3] = nid; set_slot(3, nid); nid = nid + 16'h1;
        ids[4] = nid; set_slot(4, nid); nid = nid + 16'h1;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_wb0", 128'(wb[0]), 128'(0));
        chk("midrst_wb1", 128'(wb[1]), 128'(0));
        chk("midrst_rrptr", 128'(dut.rrptr_q), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin from k=0 with claimed slots refilled
        for (int c = 0; c < 5; c++) begin
            base = (2 * c) % int'(NSLOT);
            step(NSLOT'(2'b11) << base, mk(ids[base]), mk(ids[base+1]),
                 $sformatf("rr%0d", c));
            ids[base]   = nid; set_slot(base, nid);   nid = nid + 16'h1;
            ids[base+1] = nid; set_slot(base+1, nid); nid = nid + 16'h1;
        end
        chk("rr_rrptr", 128'(dut.rrptr_q), 128'(2));

        // Drain: results are valid for one cycle only
        resp_flat = '0;
        step(8'h00, z, z, "drain");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
